tmw_multi_window_counter: RTL and testbench
===========================================

# tmw_multi_window_counter

Multi-channel time-measurement-window counter for the TRNG entropy path. It opens a programmable window and counts per-channel event strobes (sampled ring-oscillator edges) while the window is open. At window close it hands the counts off through a valid/ready result port. It supports one-shot and continuous back-to-back windows, per-channel saturation flags and a sticky overrun flag.

## Interface
- N, 5: window counter width; window length up to 2^N cycles.
- CH, 4: number of event channels.
- CW, 8: per-channel event count width.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to open a window; honoured only in IDLE.
- max_counts  in  N  window length minus one, captured on accepted start.
- mode  in  1  0 = one-shot, 1 = continuous; captured on accepted start.
- stop  in  1  in continuous mode, finish current window and then go IDLE.
- ev_in  in  CH  per-channel event strobes, already synchronous to clk.
- en_out  out  1  window open (state RUN).
- win_count  out  N  current cycle index within window.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  CH*CW  channel k count at bits [k*CW +: CW].
- res_sat  out  CH  channel k saturated during that window.
- overrun  out  1  sticky; a window result was dropped.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE, start=1: the following happen:
  - max_reg ← max_counts, mode_reg ← mode.
  - win_count ← 0; accumulators and sat bits ← 0; overrun ← 0.
  - Next state is RUN.
- RUN, every cycle: for each k with ev_in[k]=1, acc[k] ← acc[k]+1. The increment saturates at 2^CW−1 and sets sat[k].
- RUN, win_count ≠ max_reg: win_count ← win_count+1.
- RUN, win_count == max_reg (window end): the final-cycle events are included, then the result transfers. After transfer:
  - If mode_reg=1 and stop=0, stay RUN with win_count, acc and sat ← 0.
  - Otherwise go IDLE.
- Window length is max_reg+1 cycles. max_counts=0 gives a 1-cycle window; all-ones gives 2^N cycles.
- Result transfer at window end:
  - If res_valid=0, or res_valid=1 with res_ready=1 in the same cycle, res_data/res_sat ← acc/sat and res_valid ← 1.
  - Otherwise the new result is dropped, overrun ← 1, and the held result is unchanged.
- res_valid & res_ready without a window end: res_valid ← 0; res_data is held.
- start while in RUN is ignored; mode and max_counts changes mid-window are ignored.
- stop while in IDLE or mode_reg=0 has no effect.
- overrun clears only on rst or an accepted start.

## Timing
- Reset values: en_out 0, win_count 0, res_valid 0, res_data 0, res_sat 0, overrun 0; internal max_reg, mode_reg and accumulators are 0.
- start sampled at edge t → en_out=1 from cycle t+1 for exactly max_reg+1 cycles.
- ev_in is counted in the cycles where en_out=1 only.
- res_valid rises in the cycle after the last en_out=1 cycle: 1-cycle latency from window end.
- Continuous mode: en_out stays high across windows with no gap. Consecutive results appear every max_reg+1 cycles.
- res_data and res_sat are stable while res_valid=1 until the handshake completes.
- rst at any edge returns to IDLE with reset values; an in-flight window produces no result.

## Structure
- Package tmw_pkg holds:
  - the state enum (IDLE, RUN);
  - mode constants TMW_ONESHOT=0 and TMW_CONT=1.
- Sub-module tmw_sat_counter (inputs: clear, inc; outputs: count and sat; parameter CW) is instantiated CH times.
- The window FSM, result register and overrun logic stay in the top level.

## Test plan
- One-shot window:
  - Stimulus: N=5, max_counts=9, mode=0; ev_in[0] high every cycle, ev_in[1] high on alternate cycles.
  - Response: en_out high 10 cycles; res_data ch0=10, ch1=5; res_valid 1 cycle after en_out falls; then IDLE.
- Minimum and maximum windows:
  - max_counts=0 → en_out high 1 cycle, ch0=1.
  - max_counts=31 → 32 cycles, ch0=32.
- Saturation: CW=4, ev_in[2] constantly high, max_counts=20 → ch2=15, res_sat[2]=1, other sat bits 0.
- Continuous mode, stop and overrun:
  - mode=1, max_counts=3, res_ready=1 → a result every 4 cycles with no en_out gap.
  - Assert stop mid-window → that window completes, then IDLE.
  - With res_ready=0 → 2nd window end sets overrun=1 and the first result is held.
- Simultaneous events:
  - res_ready=1 exactly at a window-end cycle while res_valid=1 → new result loads, no overrun.
  - start during RUN is ignored (window length unchanged).
- Reset mid-window: rst asserted at win_count=4 → next cycle en_out=0, win_count=0, res_valid=0, no result emitted; a subsequent start works normally.

Source files
------------

// File: rtl/tmw_pkg.sv
// Shared definitions for the time-measurement-window counter.
//   tmw_state_e : window FSM state (IDLE, RUN)
//   TMW_ONESHOT : mode value for a single window
//   TMW_CONT    : mode value for back-to-back windows
package tmw_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmw_state_e;

    localparam logic TMW_ONESHOT = 1'b0;
    localparam logic TMW_CONT    = 1'b1;

endpackage

// File: rtl/tmw_sat_counter.sv
// Saturating event counter for one channel.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the stored count and sat flag at this edge
//   inc      : count one event this cycle
//   count    : stored count plus this cycle's event (saturating)
//   sat      : an event was lost to saturation, including this cycle
// count/sat include the current cycle so the parent can capture a window
// result at the same edge that clears the counter for the next window.
module tmw_sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          sat
);

    logic [CW-1:0] cnt_q;
    logic          sat_q;

    always_comb begin
        count = cnt_q;
        sat   = sat_q;
        if (inc) begin
            if (cnt_q == '1) begin
                sat = 1'b1;
            end else begin
                count = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= count;
            sat_q <= sat;
        end
    end

endmodule

// File: rtl/tmw_multi_window_counter.sv
// Multi-channel time-measurement-window counter.
// Opens a window of max_counts+1 cycles, counts per-channel event strobes
// while open, and hands the counts off through a valid/ready result port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : open a window (honoured in IDLE only)
//   max_counts : window length minus one, captured on start
//   mode       : TMW_ONESHOT / TMW_CONT, captured on start
//   stop       : in continuous mode, go IDLE after the current window
//   ev_in      : per-channel event strobes
//   en_out     : window open
//   win_count  : cycle index within the window
//   res_valid, res_ready, res_data, res_sat : result handshake and payload
//   overrun    : sticky, a window result was dropped
module tmw_multi_window_counter
    import tmw_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned CH = 4,
    parameter int unsigned CW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     max_counts,
    input  logic             mode,
    input  logic             stop,
    input  logic [CH-1:0]    ev_in,
    output logic             en_out,
    output logic [N-1:0]     win_count,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH*CW-1:0] res_data,
    output logic [CH-1:0]    res_sat,
    output logic             overrun
);

    tmw_state_e      state;
    logic [N-1:0]    max_reg;
    logic            mode_reg;

    logic            run;
    logic            win_end;
    logic            keep_run;
    logic            acc_clear;
    logic            res_load;
    logic            res_take;
    logic [CH*CW-1:0] acc_all;
    logic [CH-1:0]   sat_all;

    assign run      = (state == RUN);
    assign win_end  = run && (win_count == max_reg);
    assign keep_run = win_end && (mode_reg == TMW_CONT) && !stop;
    // Cleared when a window opens, and at a continuous window boundary after
    // the final-cycle events have been folded into the captured result.
    assign acc_clear = ((state == IDLE) && start) || keep_run;
    assign res_take  = res_valid && res_ready;
    // A window-end result is accepted if the slot is free or frees this cycle.
    assign res_load  = win_end && (!res_valid || res_ready);
    assign en_out    = run;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        tmw_sat_counter #(
            .CW(CW)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .clear(acc_clear),
            .inc  (run & ev_in[k]),
            .count(acc_all[k*CW +: CW]),
            .sat  (sat_all[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            max_reg   <= '0;
            mode_reg  <= TMW_ONESHOT;
            win_count <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_sat   <= '0;
            overrun   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        max_reg   <= max_counts;
                        mode_reg  <= mode;
                        win_count <= '0;
                        overrun   <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (win_end) begin
                        win_count <= '0;
                        state     <= keep_run ? RUN : IDLE;
                        if (!res_load) begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        win_count <= win_count + N'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (res_load) begin
                res_data  <= acc_all;
                res_sat   <= sat_all;
                res_valid <= 1'b1;
            end else if (res_take) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmw_multi_window_counter.sv
module tb_tmw_multi_window_counter;

    localparam int N  = 5;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  max_counts = '0;
    logic          mode = 1'b0;
    logic          stop = 1'b0;
    logic [CH-1:0] ev_in = '0;
    logic          res_ready = 1'b0;

    logic          en_a, en_b, rv_a, rv_b, ovr_a, ovr_b;
    logic [N-1:0]  wc_a, wc_b;
    logic [CH*8-1:0] rd_a;
    logic [CH*4-1:0] rd_b;
    logic [CH-1:0] rs_a, rs_b;

    always #5 clk = ~clk;

    tmw_multi_window_counter #(.N(N), .CH(CH), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .max_counts(max_counts), .mode(mode),
        .stop(stop), .ev_in(ev_in), .en_out(en_a), .win_count(wc_a), .res_valid(rv_a),
        .res_ready(res_ready), .res_data(rd_a), .res_sat(rs_a), .overrun(ovr_a)
    );

    // Narrow counters so the same stimulus also exercises saturation.
    tmw_multi_window_counter #(.N(N), .CH(CH), .CW(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .max_counts(max_counts), .mode(mode),
        .stop(stop), .ev_in(ev_in), .en_out(en_b), .win_count(wc_b), .res_valid(rv_b),
        .res_ready(res_ready), .res_data(rd_b), .res_sat(rs_b), .overrun(ovr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw (unbounded) event totals per window, one result slot.
    typedef logic [CH-1:0][7:0] raw_t;
    raw_t exp_q[$];
    bit   m_run = 0, m_cont = 0, m_slot = 0, m_ovr = 0;
    int   m_idx = 0, m_max = 0;
    int   m_cnt[CH];

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic model_step();
        bit   hs;
        raw_t r;
        hs = m_slot && res_ready;
        if (rst) begin
            m_run = 0; m_idx = 0; m_slot = 0; m_ovr = 0;
            exp_q.delete();
        end else if (!m_run) begin
            if (hs) m_slot = 0;
            if (start) begin
                m_run = 1; m_max = int'(max_counts); m_cont = mode; m_idx = 0; m_ovr = 0;
                for (int k = 0; k < CH; k++) m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < CH; k++) if (ev_in[k]) m_cnt[k]++;
            if (m_idx == m_max) begin
                if (!m_slot || res_ready) begin
                    for (int k = 0; k < CH; k++) r[k] = 8'(m_cnt[k]);
                    exp_q.push_back(r);
                    m_slot = 1;
                end else begin
                    m_ovr = 1;
                end
                if (m_cont && !stop) begin
                    m_idx = 0;
                    for (int k = 0; k < CH; k++) m_cnt[k] = 0;
                end else begin
                    m_run = 0;
                    m_idx = 0;
                end
            end else begin
                m_idx++;
                if (hs) m_slot = 0;
            end
        end
    endtask

    function automatic logic [63:0] exp_data(raw_t r, int cw);
        logic [63:0] d;
        int lim, v;
        d = '0;
        lim = (1 << cw) - 1;
        for (int k = 0; k < CH; k++) begin
            v = int'(r[k]);
            d |= 64'(v > lim ? lim : v) << (k * cw);
        end
        return d;
    endfunction

    function automatic logic [63:0] exp_sat(raw_t r, int cw);
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < CH; k++) s[k] = (int'(r[k]) > (1 << cw) - 1);
        return s;
    endfunction

    // Monitor: per-cycle status against the model, payload popped on handshake.
    bit mon_on = 0;
    initial begin
        raw_t r;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                check("en_out",      64'(en_a),  64'(m_run));
                check("win_count",   64'(wc_a),  64'(m_idx));
                check("res_valid",   64'(rv_a),  64'(m_slot));
                check("overrun",     64'(ovr_a), 64'(m_ovr));
                check("res_valid_b", 64'(rv_b),  64'(m_slot));
                check("overrun_b",   64'(ovr_b), 64'(m_ovr));
                if (rv_a && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        r = exp_q.pop_front();
                        check("res_data",   64'(rd_a), exp_data(r, 8));
                        check("res_sat",    64'(rs_a), exp_sat(r, 8));
                        check("res_data_b", 64'(rd_b), exp_data(r, 4));
                        check("res_sat_b",  64'(rs_b), exp_sat(r, 4));
                    end
                end
            end
        end
    end

    // Stimulus
    int ev_mode = 0;
    int cyc = 0;

    task automatic step(int n);
        repeat (n) begin
            case (ev_mode)
                0: ev_in = {2'b00, cyc[0], 1'b1};
                1: ev_in = 4'b0100;
                2: ev_in = CH'($urandom);
                default: ev_in = '0;
            endcase
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(int mx, bit md);
        max_counts = N'(mx);
        mode = md;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int guard;
        @(posedge clk);
        #1;
        mon_on = 1;
        step(2);
        rst = 1'b0;
        check("reset_res_data",   64'(rd_a), 64'(0));
        check("reset_res_sat",    64'(rs_a), 64'(0));
        check("reset_res_data_b", 64'(rd_b), 64'(0));

        // One-shot, min and max windows.
        res_ready = 1'b1;
        ev_mode = 0;
        do_start(9, 0);  step(14);
        do_start(0, 0);  step(4);
        do_start(31, 0); step(36);

        // Saturation on the narrow instance only for ch2.
        ev_mode = 1;
        do_start(20, 0); step(25);

        // Continuous, then stop held across a window end.
        ev_mode = 2;
        do_start(3, 1);  step(12);
        stop = 1'b1;     step(5);
        stop = 1'b0;

        // Overrun: nobody accepts results.
        res_ready = 1'b0;
        do_start(3, 1);  step(10);
        stop = 1'b1;     step(5);
        stop = 1'b0;
        res_ready = 1'b1; step(3);

        // Ready only at window-end cycles: load and pop in the same cycle.
        res_ready = 1'b0;
        do_start(3, 1);
        for (int i = 0; i < 16; i++) begin
            res_ready = m_run && (m_idx == m_max);
            step(1);
        end
        stop = 1'b1; res_ready = 1'b1; step(5);
        stop = 1'b0;

        // start and setting changes mid-window are ignored.
        do_start(9, 0); step(3);
        max_counts = 5'd2; mode = 1'b1; start = 1'b1; step(1);
        start = 1'b0; step(12);

        // Reset mid-window at win_count 4.
        do_start(9, 0);
        guard = 0;
        while (m_idx != 4 && guard < 20) begin
            step(1);
            guard++;
        end
        check("reached_idx4", 64'(m_idx), 64'(4));
        rst = 1'b1; step(1); rst = 1'b0;
        check("rst_res_data", 64'(rd_a), 64'(0));
        do_start(5, 0); step(10);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            start      = ($urandom_range(7) == 0);
            max_counts = N'($urandom);
            mode       = 1'($urandom);
            stop       = ($urandom_range(3) == 0);
            res_ready  = 1'($urandom);
            rst        = ($urandom_range(299) == 0);
            step(1);
        end
        rst = 1'b0;

        // Drain.
        start = 1'b0; stop = 1'b1; res_ready = 1'b1;
        step(40);
        check("all_results_seen", 64'(exp_q.size()), 64'(0));

        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
